// File: rtl/game_pkg.sv
// Shared constants, state encoding and glyph addressing helper for the
// game-over text overlay.
package game_pkg;

  localparam int GLYPH_W    = 20;
  localparam int GLYPH_H    = 20;
  localparam int GLYPH_BITS = 400;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W    = $clog2(SCREEN_W);

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_REVEAL = 2'd1;
  localparam logic [1:0] ENC_BLINK  = 2'd2;
  localparam logic [1:0] ENC_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ENC_IDLE,
    ST_REVEAL = ENC_REVEAL,
    ST_BLINK  = ENC_BLINK,
    ST_HOLD   = ENC_HOLD
  } state_t;

  // Row-major glyph with the MSB at the top-left cell; row*20 built from shifts.
  function automatic logic [8:0] glyph_bit_idx(input logic [4:0] row, input logic [4:0] col);
    logic [8:0] row20;
    row20 = ({4'b0, row} << 4) + ({4'b0, row} << 2);
    return 9'(GLYPH_BITS - 1) - (row20 + {4'b0, col});
  endfunction

endpackage

// File: rtl/game_over_text_ctrl_if.sv
// Raster, game-control and glyph ROM signals of the game-over text overlay.
interface game_over_text_ctrl_if;
  import game_pkg::*;

  logic                    game_over;
  logic                    restart;
  logic                    frame_tick;
  logic                    video_on;
  logic [PIX_W-1:0]        pixel_x;
  logic [$clog2(SCREEN_H)-1:0] pixel_y;
  logic [GLYPH_BITS-1:0]   letter_count_over;
  logic [3:0]              selected_letter_over;
  logic                    text_pixel;
  logic                    text_active;

  modport master (
    output game_over, restart, frame_tick, video_on, pixel_x, pixel_y, letter_count_over,
    input  selected_letter_over, text_pixel, text_active
  );

  modport slave (
    input  game_over, restart, frame_tick, video_on, pixel_x, pixel_y, letter_count_over,
    output selected_letter_over, text_pixel, text_active
  );
endinterface

// File: rtl/game_over_text_ctrl_text_raster_addr.sv
// Text-box geometry: in_box decode, column/glyph counters that track the
// raster without dividers, the ROM letter select and one stage of delay so
// the glyph coordinates line up with the ROM data.
module text_raster_addr
  import game_pkg::*;
#(
  parameter int TEXT_X0     = 230,
  parameter int TEXT_Y0     = 230,
  parameter int NUM_LETTERS = 9
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       video_on_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  output logic [3:0] sel_o,
  output logic       in_box_d_o,
  output logic       video_on_d_o,
  output logic [4:0] col_d_o,
  output logic [4:0] row_d_o,
  output logic [3:0] pos_d_o
);

  localparam logic [9:0] X_LO = 10'(TEXT_X0);
  localparam logic [9:0] X_HI = 10'(TEXT_X0 + GLYPH_W * NUM_LETTERS);
  localparam logic [9:0] Y_LO = 10'(TEXT_Y0);
  localparam logic [9:0] Y_HI = 10'(TEXT_Y0 + GLYPH_H);

  logic       in_box, at_x0, col_last;
  logic [4:0] col_q, col_cur, row_cur;
  logic [3:0] pos_q, pos_cur;
  logic [3:0] sel_q, pos_d_q;
  logic [4:0] col_d_q, row_d_q;
  logic       in_box_d_q, video_on_d_q;

  assign in_box   = (pixel_x_i >= X_LO) && (pixel_x_i < X_HI) &&
                    (pixel_y_i >= Y_LO) && (pixel_y_i < Y_HI);
  assign at_x0    = (pixel_x_i == X_LO);
  // The left edge of the box re-seeds the counters for the current pixel.
  assign col_cur  = at_x0 ? 5'd0 : col_q;
  assign pos_cur  = at_x0 ? 4'd0 : pos_q;
  assign col_last = (col_cur == 5'(GLYPH_W - 1));
  assign row_cur  = 5'(pixel_y_i - Y_LO);

  // Column/glyph counters prepared for the next pixel of the line.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      pos_q <= '0;
    end else if (in_box) begin
      col_q <= col_last ? 5'd0 : col_cur + 5'd1;
      pos_q <= col_last ? pos_cur + 4'd1 : pos_cur;
    end
  end

  // Stage 0: letter select to the ROM and coordinate delay for stage 1.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      sel_q        <= '0;
      in_box_d_q   <= 1'b0;
      video_on_d_q <= 1'b0;
      col_d_q      <= '0;
      row_d_q      <= '0;
      pos_d_q      <= '0;
    end else begin
      if (in_box) sel_q <= pos_cur;
      in_box_d_q   <= in_box;
      video_on_d_q <= video_on_i;
      col_d_q      <= col_cur;
      row_d_q      <= row_cur;
      pos_d_q      <= pos_cur;
    end
  end

  assign sel_o        = sel_q;
  assign in_box_d_o   = in_box_d_q;
  assign video_on_d_o = video_on_d_q;
  assign col_d_o      = col_d_q;
  assign row_d_o      = row_d_q;
  assign pos_d_o      = pos_d_q;

endmodule

// File: rtl/game_over_text_ctrl.sv
// Game-over text overlay: reveal/blink/hold sequencing on frame ticks and
// glyph bit extraction for the pixel colour mux.
//
// state  | meaning
// IDLE   | no text drawn, waiting for game_over
// REVEAL | letters appear one at a time, every REVEAL_FRAMES frames
// BLINK  | full text, toggling every BLINK_FRAMES frames
// HOLD   | game_over dropped without restart, full text steady
module game_over_text_ctrl
  import game_pkg::*;
#(
  parameter int TEXT_X0       = 230,
  parameter int TEXT_Y0       = 230,
  parameter int NUM_LETTERS   = 9,
  parameter int REVEAL_FRAMES = 15,
  parameter int BLINK_FRAMES  = 30
) (
  input logic clock_25,
  input logic reset,
  game_over_text_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] revealed_q, revealed_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       blink_on_q, blink_on_d;

  logic [3:0] sel, pos_d;
  logic [4:0] col_d, row_d;
  logic       in_box_d, video_on_d, visible, glyph_bit, text_pixel_q;

  text_raster_addr #(
    .TEXT_X0    (TEXT_X0),
    .TEXT_Y0    (TEXT_Y0),
    .NUM_LETTERS(NUM_LETTERS)
  ) u_raster (
    .clock_25    (clock_25),
    .reset       (reset),
    .video_on_i  (bus.video_on),
    .pixel_x_i   (bus.pixel_x),
    .pixel_y_i   (bus.pixel_y),
    .sel_o       (sel),
    .in_box_d_o  (in_box_d),
    .video_on_d_o(video_on_d),
    .col_d_o     (col_d),
    .row_d_o     (row_d),
    .pos_d_o     (pos_d)
  );

  // FSM state and reveal/blink bookkeeping.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      revealed_q  <= '0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      revealed_q  <= revealed_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Next state: restart beats a game_over drop, which beats frame_tick.
  always_comb begin
    state_d     = state_q;
    revealed_d  = revealed_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.game_over && !bus.restart) begin
          state_d     = ST_REVEAL;
          revealed_d  = 4'd1;
          frame_cnt_d = '0;
        end
      end
      ST_REVEAL, ST_BLINK: begin
        if (bus.restart) begin
          state_d     = ST_IDLE;
          revealed_d  = '0;
          frame_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (!bus.game_over) begin
          state_d = ST_HOLD;
        end else if (bus.frame_tick) begin
          if (state_q == ST_REVEAL) begin
            if (frame_cnt_q == 5'(REVEAL_FRAMES - 1)) begin
              frame_cnt_d = '0;
              revealed_d  = revealed_q + 4'd1;
              if (revealed_d == 4'(NUM_LETTERS)) begin
                state_d    = ST_BLINK;
                blink_on_d = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 5'd1;
            end
          end else begin
            if (frame_cnt_q == 5'(BLINK_FRAMES - 1)) begin
              frame_cnt_d = '0;
              blink_on_d  = !blink_on_q;
            end else begin
              frame_cnt_d = frame_cnt_q + 5'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (bus.restart) begin
          state_d     = ST_IDLE;
          revealed_d  = '0;
          frame_cnt_d = '0;
          blink_on_d  = 1'b1;
        end
      end
    endcase
  end

  // Per-letter visibility for the glyph currently at stage 1.
  always_comb begin
    visible = 1'b0;
    unique case (state_q)
      ST_REVEAL: visible = (pos_d < revealed_q);
      ST_BLINK:  visible = blink_on_q;
      ST_HOLD:   visible = 1'b1;
      ST_IDLE:   visible = 1'b0;
    endcase
  end

  assign glyph_bit = bus.letter_count_over[glyph_bit_idx(row_d, col_d)];

  // Stage 2: registered text pixel.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) text_pixel_q <= 1'b0;
    else       text_pixel_q <= glyph_bit & in_box_d & video_on_d & visible;
  end

  assign bus.selected_letter_over = sel;
  assign bus.text_pixel           = text_pixel_q;
  assign bus.text_active          = (state_q != ST_IDLE);

endmodule
